// File: rtl/tomasulo_core_param.sv
// Tomasulo issue/execute core: renamed issue into per-class reservation stations,
// one add/sub and one mul/div unit, and a single registered common data bus.
module tomasulo_core_param #(
    parameter int DATA_W  = 16,
    parameter int N_ADD   = 3,
    parameter int N_MUL   = 2,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    localparam int N_RS   = N_ADD + N_MUL,
    localparam int TAG_W  = $clog2(N_RS + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    input  logic              rf_wr_en,
    input  logic [3:0]        rf_wr_addr,
    input  logic [DATA_W-1:0] rf_wr_data,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [N_RS-1:0]   rs_busy,
    output logic              idle
);
    localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ((ADD_LAT > DIV_LAT) ? ADD_LAT : DIV_LAT)
                                                 : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [DATA_W-1:0] r_rf [16];
    logic [TAG_W-1:0]  r_qi [16];
    logic [N_RS-1:0]   r_busy, r_exec, r_fn;
    logic [DATA_W-1:0] r_vj [N_RS];
    logic [DATA_W-1:0] r_vk [N_RS];
    logic [TAG_W-1:0]  r_qj [N_RS];
    logic [TAG_W-1:0]  r_qk [N_RS];

    logic              r_add_act, r_add_sub, r_mul_act, r_mul_div;
    logic [CNT_W-1:0]  r_add_cnt, r_mul_cnt;
    logic [TAG_W-1:0]  r_add_tag, r_mul_tag;
    logic [DATA_W-1:0] r_add_a, r_add_b, r_mul_a, r_mul_b;
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;

    logic [2:0]        w_op;
    logic [3:0]        w_rd, w_rs, w_rt;
    logic              w_unused_msb;
    logic              w_add_free, w_mul_free, w_issue;
    logic [TAG_W-1:0]  w_add_tag, w_mul_tag, w_alloc_tag, w_alloc_idx;
    logic [TAG_W-1:0]  w_qj, w_qk, w_add_sel, w_mul_sel;
    logic [DATA_W-1:0] w_vj, w_vk, w_add_res, w_mul_res;
    logic              w_add_rdy, w_mul_rdy, w_add_go, w_mul_go;
    logic              w_add_done, w_mul_done, w_add_win, w_mul_win;

    assign w_op         = instr[2:0];
    assign w_rd         = instr[6:3];
    assign w_rs         = instr[10:7];
    assign w_rt         = instr[14:11];
    assign w_unused_msb = instr[15];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_add_free = 1'b0;
        w_add_tag  = '0;
        w_mul_free = 1'b0;
        w_mul_tag  = '0;
        for (int i = N_ADD - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_add_free = 1'b1;
                w_add_tag  = TAG_W'(i + 1);
            end
        end
        for (int i = N_RS - 1; i >= N_ADD; i--) begin
            if (!r_busy[i]) begin
                w_mul_free = 1'b1;
                w_mul_tag  = TAG_W'(i + 1);
            end
        end
    end

    assign instr_ready = w_op[2] | (w_op[1] ? w_mul_free : w_add_free);
    assign w_issue     = instr_valid & instr_ready & ~w_op[2];
    assign w_alloc_tag = w_op[1] ? w_mul_tag : w_add_tag;
    assign w_alloc_idx = w_alloc_tag - TAG_W'(1);

    // Sources see the pre-issue mapping; a same-cycle broadcast is bypassed in.
    always_comb begin
        w_qj = r_qi[w_rs];
        w_vj = r_rf[w_rs];
        w_qk = r_qi[w_rt];
        w_vk = r_rf[w_rt];
        if (r_cdb_valid && w_qj != '0 && w_qj == r_cdb_tag) begin
            w_qj = '0;
            w_vj = r_cdb_data;
        end
        if (r_cdb_valid && w_qk != '0 && w_qk == r_cdb_tag) begin
            w_qk = '0;
            w_vk = r_cdb_data;
        end
    end

    always_comb begin
        w_add_rdy = 1'b0;
        w_add_sel = '0;
        w_mul_rdy = 1'b0;
        w_mul_sel = '0;
        for (int i = N_ADD - 1; i >= 0; i--) begin
            if (r_busy[i] && !r_exec[i] && r_qj[i] == '0 && r_qk[i] == '0) begin
                w_add_rdy = 1'b1;
                w_add_sel = TAG_W'(i);
            end
        end
        for (int i = N_RS - 1; i >= N_ADD; i--) begin
            if (r_busy[i] && !r_exec[i] && r_qj[i] == '0 && r_qk[i] == '0) begin
                w_mul_rdy = 1'b1;
                w_mul_sel = TAG_W'(i);
            end
        end
    end

    assign w_add_go   = w_add_rdy & ~r_add_act;
    assign w_mul_go   = w_mul_rdy & ~r_mul_act;
    assign w_add_res  = r_add_sub ? r_add_a - r_add_b : r_add_a + r_add_b;
    assign w_mul_res  = r_mul_div ? ((r_mul_b == '0) ? '1 : r_mul_a / r_mul_b)
                                  : r_mul_a * r_mul_b;
    assign w_add_done = r_add_act & (r_add_cnt == '0);
    assign w_mul_done = r_mul_act & (r_mul_cnt == '0);
    assign w_mul_win  = w_mul_done;
    assign w_add_win  = w_add_done & ~w_mul_done;

    // NOTE: the register file and tag table are reset because a cleared machine
    // must read back zeros; sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= '0;
                r_qi[i] <= '0;
            end
        end else begin
            if (r_cdb_valid) begin
                for (int i = 0; i < 16; i++) begin
                    if (r_qi[i] == r_cdb_tag) begin
                        r_rf[i] <= r_cdb_data;
                        r_qi[i] <= '0;
                    end
                end
            end
            if (rf_wr_en) r_rf[rf_wr_addr] <= rf_wr_data;
            if (w_issue)  r_qi[w_rd] <= w_alloc_tag;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
            r_exec <= '0;
            r_fn   <= '0;
            for (int i = 0; i < N_RS; i++) begin
                r_vj[i] <= '0;
                r_vk[i] <= '0;
                r_qj[i] <= '0;
                r_qk[i] <= '0;
            end
        end else begin
            if (r_cdb_valid) begin
                for (int i = 0; i < N_RS; i++) begin
                    if (r_qj[i] == r_cdb_tag) begin
                        r_vj[i] <= r_cdb_data;
                        r_qj[i] <= '0;
                    end
                    if (r_qk[i] == r_cdb_tag) begin
                        r_vk[i] <= r_cdb_data;
                        r_qk[i] <= '0;
                    end
                    if (r_cdb_tag == TAG_W'(i + 1)) begin
                        r_busy[i] <= 1'b0;
                        r_exec[i] <= 1'b0;
                    end
                end
            end
            if (w_add_go) r_exec[w_add_sel] <= 1'b1;
            if (w_mul_go) r_exec[w_mul_sel] <= 1'b1;
            if (w_issue) begin
                r_busy[w_alloc_idx] <= 1'b1;
                r_exec[w_alloc_idx] <= 1'b0;
                r_fn[w_alloc_idx]   <= w_op[0];
                r_vj[w_alloc_idx]   <= w_vj;
                r_vk[w_alloc_idx]   <= w_vk;
                r_qj[w_alloc_idx]   <= w_qj;
                r_qk[w_alloc_idx]   <= w_qk;
            end
        end
    end

    // A finished unit holds its result and stays active until it wins the bus.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_add_act <= 1'b0; r_add_sub <= 1'b0; r_add_cnt <= '0; r_add_tag <= '0;
            r_add_a   <= '0;   r_add_b   <= '0;
            r_mul_act <= 1'b0; r_mul_div <= 1'b0; r_mul_cnt <= '0; r_mul_tag <= '0;
            r_mul_a   <= '0;   r_mul_b   <= '0;
        end else begin
            if (w_add_go) begin
                r_add_act <= 1'b1;
                r_add_cnt <= CNT_W'(ADD_LAT - 1);
                r_add_tag <= w_add_sel + TAG_W'(1);
                r_add_a   <= r_vj[w_add_sel];
                r_add_b   <= r_vk[w_add_sel];
                r_add_sub <= r_fn[w_add_sel];
            end else if (r_add_act) begin
                if (r_add_cnt != '0) r_add_cnt <= r_add_cnt - CNT_W'(1);
                else if (w_add_win)  r_add_act <= 1'b0;
            end
            if (w_mul_go) begin
                r_mul_act <= 1'b1;
                r_mul_cnt <= r_fn[w_mul_sel] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                r_mul_tag <= w_mul_sel + TAG_W'(1);
                r_mul_a   <= r_vj[w_mul_sel];
                r_mul_b   <= r_vk[w_mul_sel];
                r_mul_div <= r_fn[w_mul_sel];
            end else if (r_mul_act) begin
                if (r_mul_cnt != '0) r_mul_cnt <= r_mul_cnt - CNT_W'(1);
                else if (w_mul_win)  r_mul_act <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else if (w_mul_win) begin
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= r_mul_tag;
            r_cdb_data  <= w_mul_res;
        end else if (w_add_win) begin
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= r_add_tag;
            r_cdb_data  <= w_add_res;
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign rs_busy   = r_busy;
    assign idle      = ~|r_busy & ~r_add_act & ~r_mul_act & ~r_cdb_valid;

endmodule

// File: tb/tb_tomasulo_core_param.sv
// Bench for tomasulo_core_param: directed timing sequences, an arithmetic vector
// table, and random programs compared against an in-order architectural model.
module tb_tomasulo_core_param;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic        rf_wr_en = 1'b0;
    logic [3:0]  rf_wr_addr = '0;
    logic [15:0] rf_wr_data = '0;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic [4:0]  rs_busy;
    logic        idle;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic [2:0]  exp_tag;
    } vec_t;

    vec_t        vecs [11];
    logic [15:0] m_rf [16];

    tomasulo_core_param dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .rs_busy     (rs_busy),
        .idle        (idle)
    );

    always #5 clock = ~clock;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [3:0] addr, input logic [15:0] data);
        rf_wr_en = 1'b1;
        rf_wr_addr = addr;
        rf_wr_data = data;
        tick();
        rf_wr_en = 1'b0;
    endtask

    // Returns 1 time unit after the edge that accepted the instruction.
    task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [3:0] rt);
        int guard = 0;
        instr = {1'b0, rt, rs, rd, op};
        instr_valid = 1'b1;
        #1;
        while (!instr_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("issue_ready", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic wait_cdb(output logic [2:0] tag, output logic [15:0] data);
        int guard = 0;
        do begin
            tick();
            guard++;
        end while (!cdb_valid && guard < 200);
        check("cdb_seen", cdb_valid, 1);
        tag = cdb_tag;
        data = cdb_data;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!idle && guard < 300) begin
            tick();
            guard++;
        end
        check("idle_reached", idle, 1);
    endtask

    // Reads a register through "add r, r, R0" (R0 holds zero), leaving r unchanged.
    task automatic read_reg(input logic [3:0] r, output logic [15:0] data);
        logic [2:0] t;
        issue(3'b000, r, r, 4'd0);
        wait_cdb(t, data);
        wait_idle();
    endtask

    function automatic logic [15:0] model_alu(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        int unsigned prod;
        case (op)
            3'b000:  return 16'((int'(a) + int'(b)) % 65536);
            3'b001:  return 16'((int'(a) - int'(b) + 65536) % 65536);
            3'b010:  begin prod = int'(a) * int'(b); return 16'(prod % 65536); end
            default: return (b == 16'd0) ? 16'hFFFF : 16'(int'(a) / int'(b));
        endcase
    endfunction

    initial begin
        logic [2:0]  t;
        logic [15:0] d;

        vecs[0]  = '{3'b000, 16'h0005, 16'h0007, 16'h000C, 3'd1};
        vecs[1]  = '{3'b000, 16'hFFFF, 16'h0002, 16'h0001, 3'd1};
        vecs[2]  = '{3'b001, 16'h0000, 16'h0001, 16'hFFFF, 3'd1};
        vecs[3]  = '{3'b001, 16'h1234, 16'h0234, 16'h1000, 3'd1};
        vecs[4]  = '{3'b010, 16'h0100, 16'h0100, 16'h0000, 3'd4};
        vecs[5]  = '{3'b010, 16'h00FF, 16'h0101, 16'hFFFF, 3'd4};
        vecs[6]  = '{3'b010, 16'h1234, 16'h0003, 16'h369C, 3'd4};
        vecs[7]  = '{3'b011, 16'h0064, 16'h0007, 16'h000E, 3'd4};
        vecs[8]  = '{3'b011, 16'h1234, 16'h0000, 16'hFFFF, 3'd4};
        vecs[9]  = '{3'b011, 16'hFFFF, 16'h0001, 16'hFFFF, 3'd4};
        vecs[10] = '{3'b011, 16'h0005, 16'h000A, 16'h0000, 3'd4};

        // Reset state
        #12;
        check("rst_cdb_valid", cdb_valid, 0);
        check("rst_cdb_tag", cdb_tag, 0);
        check("rst_cdb_data", cdb_data, 0);
        check("rst_rs_busy", rs_busy, 0);
        check("rst_idle", idle, 1);
        check("rst_instr_ready", instr_ready, 1);
        reset_n = 1'b1;
        tick();

        // Reset in the middle of a multiply
        preload(4'd1, 16'h0055);
        preload(4'd2, 16'd3);
        preload(4'd3, 16'd4);
        issue(3'b010, 4'd1, 4'd2, 4'd3);
        tick();
        check("midrun_busy", rs_busy, 5'b01000);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrun_rst_busy", rs_busy, 0);
        check("midrun_rst_cdb", cdb_valid, 0);
        check("midrun_rst_idle", idle, 1);
        tick();
        reset_n = 1'b1;
        tick();
        read_reg(4'd1, d);
        check("midrun_r1_zero", d, 16'h0000);

        // Independent add, exact timing
        preload(4'd2, 16'd5);
        preload(4'd3, 16'd7);
        issue(3'b000, 4'd1, 4'd2, 4'd3);
        check("add_busy", rs_busy, 5'b00001);
        tick();
        tick();
        check("add_no_cdb_e2", cdb_valid, 0);
        tick();
        check("add_cdb_valid_e3", cdb_valid, 1);
        check("add_cdb_tag_e3", cdb_tag, 1);
        check("add_cdb_data_e3", cdb_data, 16'd12);
        check("add_not_idle_e3", idle, 0);
        tick();
        check("add_cdb_low_e4", cdb_valid, 0);
        check("add_idle_e4", idle, 1);
        read_reg(4'd1, d);
        check("add_r1", d, 16'd12);

        // RAW chain: add waits on the multiply's tag
        preload(4'd2, 16'd3);
        preload(4'd3, 16'd4);
        issue(3'b010, 4'd1, 4'd2, 4'd3);
        issue(3'b000, 4'd4, 4'd1, 4'd2);
        check("raw_busy", rs_busy, 5'b01001);
        wait_cdb(t, d);
        check("raw_first_tag", t, 4);
        check("raw_first_data", d, 16'd12);
        wait_cdb(t, d);
        check("raw_second_tag", t, 1);
        check("raw_second_data", d, 16'd15);
        wait_idle();
        read_reg(4'd4, d);
        check("raw_r4", d, 16'd15);
        read_reg(4'd1, d);
        check("raw_r1", d, 16'd12);

        // Structural stall on the add stations
        preload(4'd2, 16'd1);
        preload(4'd3, 16'd2);
        issue(3'b000, 4'd4, 4'd2, 4'd3);
        issue(3'b000, 4'd5, 4'd2, 4'd3);
        issue(3'b000, 4'd6, 4'd2, 4'd3);
        instr = {1'b0, 4'd3, 4'd2, 4'd7, 3'b000};
        instr_valid = 1'b1;
        #1;
        check("stall_ready_low", instr_ready, 0);
        instr = {1'b0, 4'd3, 4'd2, 4'd7, 3'b100};
        #1;
        check("stall_nop_ready", instr_ready, 1);
        instr = {1'b0, 4'd3, 4'd2, 4'd7, 3'b000};
        #1;
        begin
            int guard = 0;
            do begin
                tick();
                guard++;
            end while (!cdb_valid && guard < 50);
        end
        check("stall_first_bcast", cdb_tag, 1);
        check("stall_ready_in_bcast", instr_ready, 0);
        tick();
        check("stall_ready_after", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        check("stall_realloc_tag1", rs_busy[2:0], 3'b111);
        wait_idle();
        read_reg(4'd7, d);
        check("stall_r7", d, 16'd3);
        read_reg(4'd6, d);
        check("stall_r6", d, 16'd3);

        // CDB conflict: mul wins, add follows the next cycle
        preload(4'd2, 16'd3);
        preload(4'd3, 16'd4);
        preload(4'd5, 16'd10);
        preload(4'd6, 16'd20);
        issue(3'b010, 4'd1, 4'd2, 4'd3);
        tick();
        issue(3'b000, 4'd7, 4'd5, 4'd6);
        tick();
        tick();
        check("conf_no_cdb_e4", cdb_valid, 0);
        tick();
        check("conf_mul_valid", cdb_valid, 1);
        check("conf_mul_tag", cdb_tag, 4);
        check("conf_mul_data", cdb_data, 16'd12);
        tick();
        check("conf_add_valid", cdb_valid, 1);
        check("conf_add_tag", cdb_tag, 1);
        check("conf_add_data", cdb_data, 16'd30);
        wait_idle();
        read_reg(4'd1, d);
        check("conf_r1", d, 16'd12);
        read_reg(4'd7, d);
        check("conf_r7", d, 16'd30);

        // Op 1xx is consumed without effect
        issue(3'b010, 4'd1, 4'd2, 4'd3);
        instr = {1'b0, 4'd3, 4'd2, 4'd8, 3'b101};
        instr_valid = 1'b1;
        #1;
        check("nop_ready", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        check("nop_busy_same", rs_busy, 5'b01000);
        wait_idle();
        read_reg(4'd8, d);
        check("nop_r8_untouched", d, 16'd0);

        // Arithmetic vectors
        for (int i = 0; i < 11; i++) begin
            preload(4'd2, vecs[i].a);
            preload(4'd3, vecs[i].b);
            issue(vecs[i].op, 4'd1, 4'd2, 4'd3);
            wait_cdb(t, d);
            check($sformatf("vec%0d_tag", i), t, vecs[i].exp_tag);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp);
            wait_idle();
        end

        // Random programs against an in-order architectural model
        for (int round = 0; round < 20; round++) begin
            for (int r = 0; r < 16; r++) begin
                logic [15:0] v;
                v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
                if (r == 0) v = 16'd0;
                m_rf[r] = v;
                preload(4'(r), v);
            end
            for (int k = 0; k < 12; k++) begin
                logic [2:0] op;
                logic [3:0] rd, rs, rt;
                op = 3'($urandom_range(0, 5));
                rd = 4'($urandom_range(1, 15));
                rs = 4'($urandom_range(0, 15));
                rt = 4'($urandom_range(0, 15));
                if (!op[2]) m_rf[rd] = model_alu(op, m_rf[rs], m_rf[rt]);
                issue(op, rd, rs, rt);
                if ($urandom_range(0, 3) == 0) tick();
            end
            wait_idle();
            for (int r = 1; r < 16; r++) begin
                read_reg(4'(r), d);
                check($sformatf("rand%0d_r%0d", round, r), d, m_rf[r]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
